// File: rtl/pc_pkg.sv
// pc_pkg: opcode width and pc_op encodings shared by the PC sequencer.
package pc_pkg;
  localparam int PC_OPW = 3;
  localparam logic [PC_OPW-1:0] PC_HOLD   = 3'b000;
  localparam logic [PC_OPW-1:0] PC_INC    = 3'b001;
  localparam logic [PC_OPW-1:0] PC_LOAD   = 3'b010;
  localparam logic [PC_OPW-1:0] PC_BRANCH = 3'b011;
  localparam logic [PC_OPW-1:0] PC_CALL   = 3'b100;
  localparam logic [PC_OPW-1:0] PC_RET    = 3'b101;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address LIFO; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  assign full  = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[wp - PW'(1)];
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  // wp wraps naturally, so overwriting at wp when full discards the oldest entry
  always_ff @(posedge clk)
    if (reset) begin
      wp    <= '0;
      count <= '0;
    end else if (push) begin
      wp    <= wp + PW'(1);
      count <= full ? count : count + 1'b1;
    end else if (pop && !empty) begin
      wp    <= wp - PW'(1);
      count <= count - 1'b1;
    end
endmodule

// File: rtl/pc_seq.sv
// pc_seq: parametrised program-counter sequencer with hold/inc/load/branch/call/ret.
// Define PC_RAS_EN to build the return-address stack; otherwise CALL = LOAD and RET is illegal.
module pc_seq
  import pc_pkg::*;
#(
  parameter int              AW        = 32,
  parameter int              STEP      = 4,
  parameter logic [AW-1:0]   RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [PC_OPW-1:0]          pc_op,
  input  logic [AW-1:0]              pc_in,
  input  logic [AW-1:0]              br_off,
  output logic [AW-1:0]              pc_out,
  output logic                       op_err,
  output logic                       align_err,
  output logic                       ras_ovf,
  output logic                       ras_unf,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);
  localparam logic [AW-1:0] AMASK = AW'(STEP - 1);
  logic [AW-1:0] pc_inc, pc_nxt, ras_rdata;
  logic ras_en, ras_full, ras_empty, ras_push, ras_pop, is_ret, ret_ok, tgt, illegal;
  assign pc_inc   = pc_out + AW'(STEP);
  assign is_ret   = pc_op == PC_RET;
  assign ras_push = !stall && ras_en && pc_op == PC_CALL;
  assign ras_pop  = !stall && ras_en && is_ret;
`ifdef PC_RAS_EN
  assign ras_en = 1'b1;
  pc_ras #(.W(AW), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .reset(reset), .push(ras_push), .pop(ras_pop), .wdata(pc_inc),
    .rdata(ras_rdata), .count(ras_count), .full(ras_full), .empty(ras_empty)
  );
`else
  assign ras_en    = 1'b0;
  assign ras_rdata = '0;
  assign ras_full  = 1'b0;
  assign ras_empty = 1'b1;
  assign ras_count = '0;
`endif
  always_comb begin
    ret_ok  = is_ret && ras_en && !ras_empty;
    illegal = (pc_op[2] && pc_op[1]) || (is_ret && !ras_en);
    tgt     = pc_op == PC_LOAD || pc_op == PC_BRANCH || pc_op == PC_CALL || ret_ok;
    pc_nxt  = pc_op == PC_INC                          ? pc_inc :
              (pc_op == PC_LOAD || pc_op == PC_CALL)   ? pc_in :
              pc_op == PC_BRANCH                       ? pc_out + br_off :
              ret_ok                                   ? ras_rdata : pc_out;
  end
  always_ff @(posedge clk)
    if (reset) begin
      pc_out    <= RESET_VEC;
      op_err    <= 1'b0;
      align_err <= 1'b0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else begin
      pc_out    <= stall ? pc_out : pc_nxt;
      op_err    <= !stall && illegal;
      align_err <= !stall && tgt && |(pc_nxt & AMASK);
      ras_ovf   <= ras_push && ras_full;
      ras_unf   <= ras_pop && ras_empty;
    end
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed-vector bench for pc_seq; RAS steps run only when PC_RAS_EN is defined.
module tb_pc_seq;
  import pc_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0;
  logic [2:0]  pc_op = PC_HOLD;
  logic [31:0] pc_in = '0, br_off = '0, pc_out;
  logic        op_err, align_err, ras_ovf, ras_unf;
  logic [2:0]  ras_count;
  int n = 0, err = 0;
  pc_seq #(.AW(32), .STEP(4), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_op(pc_op), .pc_in(pc_in), .br_off(br_off),
    .pc_out(pc_out), .op_err(op_err), .align_err(align_err), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf), .ras_count(ras_count)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // flags packed as {op_err, align_err, ras_ovf, ras_unf}
  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [3:0] fl, input logic [2:0] cnt);
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".flags"}, {28'b0, op_err, align_err, ras_ovf, ras_unf}, {28'b0, fl});
    chk({tag, ".cnt"}, {29'b0, ras_count}, {29'b0, cnt});
  endtask
  task automatic op(input logic [2:0] o, input logic [31:0] in, input logic [31:0] off);
    pc_op = o; pc_in = in; br_off = off;
    cyc();
  endtask
  initial begin
    cyc(); cyc();
    chk_all("reset", 32'h100, 4'b0000, 3'd0);
    reset = 1'b0;
    op(PC_INC, 0, 0);            chk_all("inc1", 32'h104, 4'b0000, 3'd0);
    stall = 1'b1; op(PC_INC, 0, 0); chk_all("stall", 32'h104, 4'b0000, 3'd0);
    stall = 1'b0; op(PC_INC, 0, 0); chk_all("inc2", 32'h108, 4'b0000, 3'd0);
    op(PC_INC, 0, 0);            chk_all("inc3", 32'h10C, 4'b0000, 3'd0);
    op(PC_LOAD, 32'h200, 0);     chk_all("load200", 32'h200, 4'b0000, 3'd0);
    op(PC_BRANCH, 0, 32'hFFFF_FFF0); chk_all("br_back", 32'h1F0, 4'b0000, 3'd0);
    op(PC_LOAD, 32'hFFFF_FFFC, 0); chk_all("load_top", 32'hFFFF_FFFC, 4'b0000, 3'd0);
    op(PC_INC, 0, 0);            chk_all("wrap", 32'h0, 4'b0000, 3'd0);
    op(3'b110, 32'h500, 0);      chk_all("illegal", 32'h0, 4'b1000, 3'd0);
    op(PC_HOLD, 0, 0);           chk_all("err_pulse", 32'h0, 4'b0000, 3'd0);
    op(PC_LOAD, 32'h102, 0);     chk_all("misalign", 32'h102, 4'b0100, 3'd0);
    op(PC_BRANCH, 0, 32'h2);     chk_all("realign", 32'h104, 4'b0000, 3'd0);
    op(3'b111, 0, 0);            chk_all("illegal7", 32'h104, 4'b1000, 3'd0);
`ifdef PC_RAS_EN
    op(PC_LOAD, 32'h40, 0);      chk_all("load40", 32'h40, 4'b0000, 3'd0);
    op(PC_CALL, 32'h800, 0);     chk_all("call1", 32'h800, 4'b0000, 3'd1);
    op(PC_CALL, 32'h900, 0);     chk_all("call2", 32'h900, 4'b0000, 3'd2);
    stall = 1'b1; op(PC_RET, 0, 0); chk_all("ret_stall", 32'h900, 4'b0000, 3'd2);
    stall = 1'b0; op(PC_RET, 0, 0); chk_all("ret1", 32'h804, 4'b0000, 3'd1);
    op(PC_RET, 0, 0);            chk_all("ret2", 32'h44, 4'b0000, 3'd0);
    op(PC_RET, 0, 0);            chk_all("ret_unf", 32'h44, 4'b0001, 3'd0);
    op(PC_CALL, 32'h1000, 0);    chk_all("c5_1", 32'h1000, 4'b0000, 3'd1);
    op(PC_CALL, 32'h2000, 0);    chk_all("c5_2", 32'h2000, 4'b0000, 3'd2);
    op(PC_CALL, 32'h3000, 0);    chk_all("c5_3", 32'h3000, 4'b0000, 3'd3);
    op(PC_CALL, 32'h4000, 0);    chk_all("c5_4", 32'h4000, 4'b0000, 3'd4);
    op(PC_CALL, 32'h5002, 0);    chk_all("c5_ovf", 32'h5002, 4'b0110, 3'd4);
    op(PC_RET, 0, 0);            chk_all("r5_1", 32'h5002 - 32'h5002 + 32'h4004, 4'b0000, 3'd3);
    op(PC_RET, 0, 0);            chk_all("r5_2", 32'h3004, 4'b0000, 3'd2);
    op(PC_RET, 0, 0);            chk_all("r5_3", 32'h2004, 4'b0000, 3'd1);
    op(PC_RET, 0, 0);            chk_all("r5_4", 32'h1004, 4'b0000, 3'd0);
    op(PC_RET, 0, 0);            chk_all("r5_unf", 32'h1004, 4'b0001, 3'd0);
    op(PC_CALL, 32'h600, 0);     chk_all("pre_rst", 32'h600, 4'b0000, 3'd1);
`else
    op(PC_CALL, 32'h800, 0);     chk_all("call_ld", 32'h800, 4'b0000, 3'd0);
    op(PC_CALL, 32'h902, 0);     chk_all("call_mis", 32'h902, 4'b0100, 3'd0);
    op(PC_RET, 0, 0);            chk_all("ret_ill", 32'h902, 4'b1000, 3'd0);
    op(PC_CALL, 32'h600, 0);     chk_all("pre_rst", 32'h600, 4'b0000, 3'd0);
`endif
    reset = 1'b1; stall = 1'b1;
    op(PC_CALL, 32'h700, 0);     chk_all("rst_call", 32'h100, 4'b0000, 3'd0);
    reset = 1'b0; stall = 1'b0;
    op(PC_HOLD, 0, 0);           chk_all("post_rst", 32'h100, 4'b0000, 3'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
